// File: rtl/mouse_cmd_scheduler.sv
// rtl/mouse_cmd_scheduler.sv - arbitrates two PS/2 mouse command requesters over one TX/RX byte interface
module mouse_cmd_scheduler #(
    parameter int unsigned TIMEOUT_CYCLES = 5000000,
    parameter int unsigned TO_W           = 23,
    parameter int unsigned MAX_RETRY      = 3,
    parameter logic [7:0]  ACK_BYTE       = 8'hFA,
    parameter logic [7:0]  RESEND_BYTE    = 8'hFE,
    parameter logic [7:0]  ERROR_BYTE     = 8'hFC
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_a_i,
    input  logic       req_b_i,
    input  logic [7:0] cmd_a_i,
    input  logic [7:0] cmd_b_i,
    input  logic       has_arg_a_i,
    input  logic       has_arg_b_i,
    input  logic [7:0] arg_a_i,
    input  logic [7:0] arg_b_i,
    output logic       done_a_o,
    output logic       done_b_o,
    output logic [1:0] status_a_o,
    output logic [1:0] status_b_o,
    output logic       busy_o,
    output logic       send_byte_o,
    output logic [7:0] byte_to_send_o,
    input  logic       byte_sent_i,
    output logic       read_enable_o,
    input  logic [7:0] byte_read_i,
    input  logic [1:0] byte_error_code_i,
    input  logic       byte_ready_i,
    input  logic       stream_read_en_i,
    output logic       stream_byte_ready_o
);

    localparam int unsigned RW = ($clog2(MAX_RETRY + 1) < 2) ? 2 : $clog2(MAX_RETRY + 1);
    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_TO  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_SENT,
        S_WAIT_REPLY,
        S_FINISH,
        S_RELEASE
    } state_e;

    state_e          state_q;
    logic            owner_b_q;
    logic [7:0]      arg_q;
    logic            has_arg_q;
    logic            phase_arg_q;
    logic [RW-1:0]   retry_q;
    logic [TO_W-1:0] to_q;
    logic            send_byte_q;
    logic [7:0]      byte_to_send_q;
    logic            done_a_q;
    logic            done_b_q;
    logic [1:0]      status_a_q;
    logic [1:0]      status_b_q;

    logic            decisive_d;
    logic            resend_d;
    logic            next_arg_d;
    logic            fin_d;
    logic            to_hit_d;
    logic [1:0]      fin_status_d;

    // Reply decode; a decisive reply in the expiry cycle beats the timeout.
    always_comb begin
        decisive_d   = 1'b0;
        resend_d     = 1'b0;
        next_arg_d   = 1'b0;
        fin_d        = 1'b0;
        fin_status_d = ST_OK;
        to_hit_d     = (to_q == TO_W'(TIMEOUT_CYCLES - 1));
        if (state_q == S_WAIT_REPLY && byte_ready_i) begin
            if (byte_error_code_i != 2'b00 || byte_read_i == RESEND_BYTE) begin
                decisive_d = 1'b1;
                if (retry_q < RW'(MAX_RETRY)) begin
                    resend_d = 1'b1;
                end else begin
                    fin_d        = 1'b1;
                    fin_status_d = ST_ERR;
                end
            end else if (byte_read_i == ACK_BYTE) begin
                decisive_d = 1'b1;
                if (!phase_arg_q && has_arg_q) begin
                    next_arg_d = 1'b1;
                end else begin
                    fin_d = 1'b1;
                end
            end else if (byte_read_i == ERROR_BYTE) begin
                decisive_d   = 1'b1;
                fin_d        = 1'b1;
                fin_status_d = ST_ERR;
            end
        end
        if (to_hit_d && ((state_q == S_WAIT_SENT && !byte_sent_i) ||
                         (state_q == S_WAIT_REPLY && !decisive_d))) begin
            fin_d        = 1'b1;
            fin_status_d = ST_TO;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            owner_b_q      <= 1'b0;
            arg_q          <= 8'h00;
            has_arg_q      <= 1'b0;
            phase_arg_q    <= 1'b0;
            retry_q        <= '0;
            to_q           <= '0;
            send_byte_q    <= 1'b0;
            byte_to_send_q <= 8'h00;
            done_a_q       <= 1'b0;
            done_b_q       <= 1'b0;
            status_a_q     <= ST_OK;
            status_b_q     <= ST_OK;
        end else begin
            send_byte_q <= 1'b0;
            done_a_q    <= 1'b0;
            done_b_q    <= 1'b0;
            if (fin_d) begin
                state_q <= S_FINISH;
                if (owner_b_q) begin
                    done_b_q   <= 1'b1;
                    status_b_q <= fin_status_d;
                end else begin
                    done_a_q   <= 1'b1;
                    status_a_q <= fin_status_d;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (req_a_i || req_b_i) begin
                            owner_b_q      <= !req_a_i;
                            byte_to_send_q <= req_a_i ? cmd_a_i : cmd_b_i;
                            arg_q          <= req_a_i ? arg_a_i : arg_b_i;
                            has_arg_q      <= req_a_i ? has_arg_a_i : has_arg_b_i;
                            phase_arg_q    <= 1'b0;
                            retry_q        <= '0;
                            send_byte_q    <= 1'b1;
                            state_q        <= S_SEND;
                        end
                    end
                    S_SEND: begin
                        to_q    <= '0;
                        state_q <= S_WAIT_SENT;
                    end
                    S_WAIT_SENT: begin
                        if (byte_sent_i) begin
                            to_q    <= '0;
                            state_q <= S_WAIT_REPLY;
                        end else begin
                            to_q <= to_q + TO_W'(1);
                        end
                    end
                    S_WAIT_REPLY: begin
                        if (resend_d) begin
                            retry_q     <= retry_q + RW'(1);
                            send_byte_q <= 1'b1;
                            state_q     <= S_SEND;
                        end else if (next_arg_d) begin
                            phase_arg_q    <= 1'b1;
                            retry_q        <= '0;
                            byte_to_send_q <= arg_q;
                            send_byte_q    <= 1'b1;
                            state_q        <= S_SEND;
                        end else begin
                            to_q <= to_q + TO_W'(1);
                        end
                    end
                    S_FINISH: state_q <= S_RELEASE;
                    S_RELEASE: begin
                        if (owner_b_q ? !req_b_i : !req_a_i) begin
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign done_a_o            = done_a_q;
    assign done_b_o            = done_b_q;
    assign status_a_o          = status_a_q;
    assign status_b_o          = status_b_q;
    assign busy_o              = (state_q != S_IDLE);
    assign send_byte_o         = send_byte_q;
    assign byte_to_send_o      = byte_to_send_q;
    assign read_enable_o       = (state_q == S_IDLE) ? stream_read_en_i : (state_q == S_WAIT_REPLY);
    assign stream_byte_ready_o = (state_q == S_IDLE) && byte_ready_i;

endmodule
